// File: rtl/alu_arbiter_if.sv
// Bundle of requester, ALU-side and response signals around alu_arbiter.
// slave is the arbiter's view; master is the surrounding logic (requesters, ALU, consumer).
interface alu_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic [3:0]  req0_cmd;

  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic [3:0]  req1_cmd;

  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_cmd;
  logic [31:0] alu_result;
  logic        alu_carryout;
  logic        alu_zero;
  logic        alu_overflow;

  logic        resp_valid;
  logic        resp_ready;
  logic        resp_id;
  logic [31:0] resp_result;
  logic        resp_carryout;
  logic        resp_zero;
  logic        resp_overflow;
  logic        resp_err;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_cmd,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_cmd,
    output req1_ready,
    output alu_a, alu_b, alu_cmd,
    input  alu_result, alu_carryout, alu_zero, alu_overflow,
    output resp_valid, resp_id, resp_result, resp_carryout, resp_zero, resp_overflow, resp_err,
    input  resp_ready
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_cmd,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_cmd,
    input  req1_ready,
    input  alu_a, alu_b, alu_cmd,
    output alu_result, alu_carryout, alu_zero, alu_overflow,
    input  resp_valid, resp_id, resp_result, resp_carryout, resp_zero, resp_overflow, resp_err,
    output resp_ready
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one 32-bit ALU between two requesters, one op in flight.
// Define ALU_SLT_EMU_EN to issue SLT as SUB and derive the SLT bit from sign ^ overflow.
module alu_arbiter #(
  parameter int unsigned SETTLE = 2
) (
  input logic           clk_i,
  input logic           rst_i,
  alu_arbiter_if.slave  bus_io
);

  localparam logic [3:0] CmdMax = 4'd8;
`ifdef ALU_SLT_EMU_EN
  localparam logic [3:0] CmdSub = 4'd1;
  localparam logic [3:0] CmdSlt = 4'd3;
`endif

  typedef enum logic [1:0] {StIdle, StHold, StResp} state_e;

  state_e      state_q, state_d;
  logic        ptr_q, ptr_d;
  logic        id_q, id_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] alu_a_q, alu_a_d;
  logic [31:0] alu_b_q, alu_b_d;
  logic [3:0]  alu_cmd_q, alu_cmd_d;
  logic [31:0] res_q, res_d;
  logic        carry_q, carry_d;
  logic        zero_q, zero_d;
  logic        ovf_q, ovf_d;
  logic        err_q, err_d;
`ifdef ALU_SLT_EMU_EN
  logic        slt_q, slt_d;
  logic        slt_bit;
`endif

  logic        both_valid, grant0, grant1;
  logic [31:0] gnt_a, gnt_b;
  logic [3:0]  gnt_cmd;

  // ptr_q names the requester favoured when both are valid.
  always_comb begin
    both_valid = bus_io.req0_valid & bus_io.req1_valid;
    grant1     = both_valid ? ptr_q  : bus_io.req1_valid;
    grant0     = both_valid ? ~ptr_q : bus_io.req0_valid;
    gnt_a      = grant1 ? bus_io.req1_a   : bus_io.req0_a;
    gnt_b      = grant1 ? bus_io.req1_b   : bus_io.req0_b;
    gnt_cmd    = grant1 ? bus_io.req1_cmd : bus_io.req0_cmd;
  end

`ifdef ALU_SLT_EMU_EN
  assign slt_bit = bus_io.alu_result[31] ^ bus_io.alu_overflow;
`endif

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    cnt_d     = cnt_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_cmd_d = alu_cmd_q;
    res_d     = res_q;
    carry_d   = carry_q;
    zero_d    = zero_q;
    ovf_d     = ovf_q;
    err_d     = err_q;
`ifdef ALU_SLT_EMU_EN
    slt_d     = slt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (grant0 | grant1) begin
          alu_a_d   = gnt_a;
          alu_b_d   = gnt_b;
          alu_cmd_d = gnt_cmd;
          id_d      = grant1;
          cnt_d     = 4'(SETTLE - 1);
          state_d   = StHold;
`ifdef ALU_SLT_EMU_EN
          slt_d     = (gnt_cmd == CmdSlt);
          if (gnt_cmd == CmdSlt) alu_cmd_d = CmdSub;
`endif
        end
      end
      StHold: begin
        if (cnt_q == 4'd0) begin
          state_d = StResp;
          if (alu_cmd_q > CmdMax) begin
            res_d   = 32'd0;
            carry_d = 1'b0;
            zero_d  = 1'b0;
            ovf_d   = 1'b0;
            err_d   = 1'b1;
`ifdef ALU_SLT_EMU_EN
          end else if (slt_q) begin
            res_d   = {31'd0, slt_bit};
            carry_d = bus_io.alu_carryout;
            zero_d  = ~slt_bit;
            ovf_d   = bus_io.alu_overflow;
            err_d   = 1'b0;
`endif
          end else begin
            res_d   = bus_io.alu_result;
            carry_d = bus_io.alu_carryout;
            zero_d  = bus_io.alu_zero;
            ovf_d   = bus_io.alu_overflow;
            err_d   = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (bus_io.resp_ready) begin
          ptr_d   = ~id_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      ptr_q     <= 1'b0;
      id_q      <= 1'b0;
      cnt_q     <= 4'd0;
      alu_a_q   <= 32'd0;
      alu_b_q   <= 32'd0;
      alu_cmd_q <= 4'd0;
      res_q     <= 32'd0;
      carry_q   <= 1'b0;
      zero_q    <= 1'b0;
      ovf_q     <= 1'b0;
      err_q     <= 1'b0;
`ifdef ALU_SLT_EMU_EN
      slt_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      id_q      <= id_d;
      cnt_q     <= cnt_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_cmd_q <= alu_cmd_d;
      res_q     <= res_d;
      carry_q   <= carry_d;
      zero_q    <= zero_d;
      ovf_q     <= ovf_d;
      err_q     <= err_d;
`ifdef ALU_SLT_EMU_EN
      slt_q     <= slt_d;
`endif
    end
  end

  assign bus_io.req0_ready    = (state_q == StIdle) & grant0;
  assign bus_io.req1_ready    = (state_q == StIdle) & grant1;
  assign bus_io.alu_a         = alu_a_q;
  assign bus_io.alu_b         = alu_b_q;
  assign bus_io.alu_cmd       = alu_cmd_q;
  assign bus_io.resp_valid    = (state_q == StResp);
  assign bus_io.resp_id       = id_q;
  assign bus_io.resp_result   = res_q;
  assign bus_io.resp_carryout = carry_q;
  assign bus_io.resp_zero     = zero_q;
  assign bus_io.resp_overflow = ovf_q;
  assign bus_io.resp_err      = err_q;

endmodule
